// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide unit for the EX stage.
// Ports:
//   CLK       rising-edge clock
//   RESET     asynchronous active-low reset
//   START     ID/EX holds an M-extension instruction
//   ALU_OP    5-bit operation code from ID/EX
//   OPERAND1  rs1 value (forwarded)
//   OPERAND2  rs2 value (forwarded)
//   STALL     combinational freeze request to the hazard unit
//   DONE      one-cycle pulse, RESULT valid
//   RESULT    operation result, held until the next DONE
module ex_muldiv_unit #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned CNT_WIDTH  = 6
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  START,
    input  logic [4:0]            ALU_OP,
    input  logic [DATA_WIDTH-1:0] OPERAND1,
    input  logic [DATA_WIDTH-1:0] OPERAND2,
    output logic                  STALL,
    output logic                  DONE,
    output logic [DATA_WIDTH-1:0] RESULT
);

    localparam int unsigned DW = DATA_WIDTH;
    localparam int unsigned PW = 2 * DATA_WIDTH;
    localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(DATA_WIDTH - 1);
    localparam logic [DW-1:0] INT_MIN = {1'b1, {(DW-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MUL,
        ST_DIV,
        ST_DONE
    } state_t;

    state_t state, state_nxt;

    logic [CNT_WIDTH-1:0] cnt;
    logic [2:0]           op_q;
    logic                 neg_q;      // negate product / quotient
    logic                 rem_neg_q;  // remainder takes dividend sign
    logic [PW-1:0]        acc;
    logic [PW-1:0]        mcand;
    logic [DW-1:0]        mplier;
    logic [DW-1:0]        rem;
    logic [DW-1:0]        quo;
    logic [DW-1:0]        divisor;
    logic                 done_q;
    logic [DW-1:0]        result_q;

    // Operand decode at acceptance
    logic          op_valid_c, accept_c, is_div_c;
    logic          a_signed_c, b_signed_c, a_neg_c, b_neg_c;
    logic [DW-1:0] a_mag_c, b_mag_c;
    logic          div_zero_c, div_ovf_c, special_c;
    logic [DW-1:0] special_res_c;

    always_comb begin
        op_valid_c    = START & (ALU_OP[4:3] == 2'b01);
        accept_c      = (state == ST_IDLE) & op_valid_c;
        is_div_c      = ALU_OP[2];
        // mul: rs1 signed unless MULHU, rs2 signed for MUL/MULH; div: signed for DIV/REM
        a_signed_c    = is_div_c ? ~ALU_OP[0] : (ALU_OP[1:0] != 2'b11);
        b_signed_c    = is_div_c ? ~ALU_OP[0] : ~ALU_OP[1];
        a_neg_c       = a_signed_c & OPERAND1[DW-1];
        b_neg_c       = b_signed_c & OPERAND2[DW-1];
        a_mag_c       = a_neg_c ? -OPERAND1 : OPERAND1;
        b_mag_c       = b_neg_c ? -OPERAND2 : OPERAND2;
        div_zero_c    = (OPERAND2 == '0);
        div_ovf_c     = ~ALU_OP[0] & (OPERAND1 == INT_MIN) & (OPERAND2 == '1);
        special_c     = is_div_c & (div_zero_c | div_ovf_c);
        special_res_c = '0;
        if (div_zero_c) begin
            special_res_c = ALU_OP[1] ? OPERAND1 : '1;
        end else begin
            special_res_c = ALU_OP[1] ? '0 : INT_MIN;
        end
    end

    // One shift-add / restoring-divide step and final sign fix-up
    logic [PW-1:0] acc_sum_c, mul_prod_c;
    logic [DW-1:0] mul_res_c;
    logic [DW:0]   div_trial_c;
    logic [DW-1:0] rem_nxt_c, quo_nxt_c, quo_fix_c, rem_fix_c, div_res_c;

    always_comb begin
        acc_sum_c   = mplier[0] ? (acc + mcand) : acc;
        mul_prod_c  = neg_q ? -acc_sum_c : acc_sum_c;
        mul_res_c   = (op_q[1:0] == 2'b00) ? mul_prod_c[DW-1:0] : mul_prod_c[PW-1:DW];
        div_trial_c = {rem, quo[DW-1]} - {1'b0, divisor};
        if (!div_trial_c[DW]) begin
            rem_nxt_c = div_trial_c[DW-1:0];
            quo_nxt_c = {quo[DW-2:0], 1'b1};
        end else begin
            rem_nxt_c = {rem[DW-2:0], quo[DW-1]};
            quo_nxt_c = {quo[DW-2:0], 1'b0};
        end
        quo_fix_c = neg_q ? -quo_nxt_c : quo_nxt_c;
        rem_fix_c = rem_neg_q ? -rem_nxt_c : rem_nxt_c;
        div_res_c = op_q[1] ? rem_fix_c : quo_fix_c;
    end

    // State register
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and stall request; stall is forced low while reset is held
    always_comb begin
        state_nxt = state;
        STALL     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept_c) begin
                    if (special_c) begin
                        state_nxt = ST_DONE;
                    end else if (is_div_c) begin
                        state_nxt = ST_DIV;
                    end else begin
                        state_nxt = ST_MUL;
                    end
                end
                STALL = RESET & accept_c;
            end
            ST_MUL, ST_DIV: begin
                if (cnt == LAST_CNT) begin
                    state_nxt = ST_DONE;
                end
                STALL = RESET;
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Datapath registers
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            cnt       <= '0;
            op_q      <= '0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            acc       <= '0;
            mcand     <= '0;
            mplier    <= '0;
            rem       <= '0;
            quo       <= '0;
            divisor   <= '0;
            done_q    <= 1'b0;
            result_q  <= '0;
        end else begin
            done_q <= (state_nxt == ST_DONE);
            if (accept_c) begin
                cnt       <= '0;
                op_q      <= ALU_OP[2:0];
                neg_q     <= a_neg_c ^ b_neg_c;
                rem_neg_q <= a_neg_c;
                acc       <= '0;
                mcand     <= {{DW{1'b0}}, a_mag_c};
                mplier    <= b_mag_c;
                rem       <= '0;
                quo       <= a_mag_c;
                divisor   <= b_mag_c;
                if (special_c) begin
                    result_q <= special_res_c;
                end
            end else if (state == ST_MUL) begin
                cnt    <= cnt + CNT_WIDTH'(1);
                acc    <= acc_sum_c;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                if (cnt == LAST_CNT) begin
                    result_q <= mul_res_c;
                end
            end else if (state == ST_DIV) begin
                cnt <= cnt + CNT_WIDTH'(1);
                rem <= rem_nxt_c;
                quo <= quo_nxt_c;
                if (cnt == LAST_CNT) begin
                    result_q <= div_res_c;
                end
            end
        end
    end

    assign DONE   = done_q;
    assign RESULT = result_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Self-checking bench for ex_muldiv_unit: directed cases plus randomized ops
// against an arithmetic reference model.
module tb_ex_muldiv_unit;

    logic        CLK = 1'b0;
    logic        RESET = 1'b0;
    logic        START = 1'b0;
    logic [4:0]  ALU_OP = 5'd0;
    logic [31:0] OPERAND1 = 32'd0;
    logic [31:0] OPERAND2 = 32'd0;
    logic        STALL;
    logic        DONE;
    logic [31:0] RESULT;

    int total = 0;
    int bad   = 0;

    ex_muldiv_unit #(.DATA_WIDTH(32), .CNT_WIDTH(6)) dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .START    (START),
        .ALU_OP   (ALU_OP),
        .OPERAND1 (OPERAND1),
        .OPERAND2 (OPERAND2),
        .STALL    (STALL),
        .DONE     (DONE),
        .RESULT   (RESULT)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    // RV32M semantics from plain arithmetic
    function automatic logic [31:0] ref_model(input logic [2:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
        longint      sa, sb, ub;
        logic [63:0] p;
        logic [63:0] ua64, ub64;
        int          ia, ib;
        logic        ovf;
        sa   = longint'($signed(a));
        sb   = longint'($signed(b));
        ub   = longint'({32'd0, b});
        ua64 = {32'd0, a};
        ub64 = {32'd0, b};
        ia   = $signed(a);
        ib   = $signed(b);
        ovf  = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        p    = '0;
        ref_model = '0;
        case (op)
            3'd0: begin p = sa * sb;     ref_model = p[31:0];  end
            3'd1: begin p = sa * sb;     ref_model = p[63:32]; end
            3'd2: begin p = sa * ub;     ref_model = p[63:32]; end
            3'd3: begin p = ua64 * ub64; ref_model = p[63:32]; end
            3'd4: ref_model = (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'(ia / ib);
            3'd5: ref_model = (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: ref_model = (b == 0) ? a : ovf ? 32'd0 : 32'(ia % ib);
            default: ref_model = (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int exp_latency(input logic [4:0] op, input logic [31:0] a,
                                       input logic [31:0] b);
        if (op[2] && (b == 0 || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)))
            return 1;
        return 33;
    endfunction

    // Issue one op; START stays high until the DONE cycle, as a frozen ID/EX would
    task automatic run_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input bit toggle, input string tag);
        int cyc;
        bit stall_ok;
        stall_ok = 1'b1;
        @(negedge CLK);
        START = 1'b1; ALU_OP = op; OPERAND1 = a; OPERAND2 = b;
        #1;
        chk({tag, " stall0"}, 32'(STALL), 32'd1);
        cyc = 0;
        while (cyc < 40) begin
            @(negedge CLK);
            cyc++;
            if (DONE === 1'b1) break;
            if (STALL !== 1'b1) stall_ok = 1'b0;
            if (toggle) begin
                OPERAND1 = $urandom;
                OPERAND2 = $urandom;
                ALU_OP   = 5'(8 + $urandom_range(0, 7));
            end
        end
        chk({tag, " latency"}, 32'(cyc), 32'(exp_latency(op, a, b)));
        chk({tag, " result"}, RESULT, exp);
        chk({tag, " stall_busy"}, 32'(stall_ok), 32'd1);
        chk({tag, " stall_done"}, 32'(STALL), 32'd0);
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 3))
            0: return $urandom;
            1: return 32'($urandom_range(0, 15));
            2: case ($urandom_range(0, 3))
                   0: return 32'd0;
                   1: return 32'hFFFF_FFFF;
                   2: return 32'h8000_0000;
                   default: return 32'd1;
               endcase
            default: return -32'($urandom_range(1, 16));
        endcase
    endfunction

    initial begin
        bit flag;
        logic [4:0]  rop;
        logic [31:0] ra, rb;

        repeat (3) @(negedge CLK);
        chk("reset stall", 32'(STALL), 32'd0);
        chk("reset done", 32'(DONE), 32'd0);
        chk("reset result", RESULT, 32'd0);
        RESET = 1'b1;

        run_op(5'b01000, 32'hFFFF_FFF9, 32'h3, 32'hFFFF_FFEB, 1'b0, "mul_neg7x3");
        run_op(5'b01001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, "mulh");
        run_op(5'b01010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "mulhsu");
        run_op(5'b01011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, "mulhu");
        run_op(5'b01100, 32'hFFFF_FFEC, 32'd3, 32'hFFFF_FFFA, 1'b0, "div_m20_3");
        run_op(5'b01110, 32'hFFFF_FFEC, 32'd3, 32'hFFFF_FFFE, 1'b0, "rem_m20_3");
        run_op(5'b01101, 32'd20, 32'd3, 32'd6, 1'b0, "divu_20_3");
        run_op(5'b01111, 32'd20, 32'd3, 32'd2, 1'b0, "remu_20_3");
        run_op(5'b01100, 32'd5, 32'd0, 32'hFFFF_FFFF, 1'b0, "div_by0");
        run_op(5'b01100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, "div_ovf");
        run_op(5'b01110, 32'd5, 32'd0, 32'd5, 1'b0, "rem_by0");

        // Back-to-back with operands toggling while busy
        run_op(5'b01000, 32'd100, 32'd200, 32'd20000, 1'b1, "b2b_first");
        run_op(5'b01000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 1'b1, "b2b_second");
        @(negedge CLK);
        START = 1'b0;
        chk("done_pulse_one_cycle", 32'(DONE), 32'd0);

        // Non-M opcode is ignored
        START = 1'b1; ALU_OP = 5'b00000; OPERAND1 = 32'd9; OPERAND2 = 32'd9;
        #1;
        chk("invalid_op stall", 32'(STALL), 32'd0);
        flag = 1'b0;
        repeat (6) begin
            @(negedge CLK);
            if (DONE !== 1'b0 || STALL !== 1'b0) flag = 1'b1;
        end
        chk("invalid_op idle", 32'(flag), 32'd0);
        START = 1'b0;

        // Reset mid-divide: RESULT still holds 1 from the last multiply
        @(negedge CLK);
        START = 1'b1; ALU_OP = 5'b01101; OPERAND1 = 32'd100; OPERAND2 = 32'd7;
        repeat (10) @(negedge CLK);
        chk("midop stall", 32'(STALL), 32'd1);
        #2 RESET = 1'b0;
        #1;
        chk("async_reset stall", 32'(STALL), 32'd0);
        chk("async_reset done", 32'(DONE), 32'd0);
        chk("async_reset result", RESULT, 32'd0);
        START = 1'b0;
        @(negedge CLK);
        RESET = 1'b1;
        flag = 1'b0;
        repeat (40) begin
            @(negedge CLK);
            if (DONE !== 1'b0 || STALL !== 1'b0 || RESULT !== 32'd0) flag = 1'b1;
        end
        chk("post_reset idle", 32'(flag), 32'd0);

        // Randomized ops against the reference model
        for (int i = 0; i < 30; i++) begin
            rop = 5'(8 + $urandom_range(0, 7));
            ra  = pick_operand();
            rb  = pick_operand();
            run_op(rop, ra, rb, ref_model(rop[2:0], ra, rb), 1'($urandom_range(0, 1)),
                   $sformatf("rand%0d op=%b a=%h b=%h", i, rop, ra, rb));
        end
        @(negedge CLK);
        START = 1'b0;
        repeat (3) @(negedge CLK);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
